// File: rtl/mux_scan_defs.sv
// rtl/mux_scan_defs.sv - shared state encodings and counter width for the mux channel scanner
package mux_scan_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int CNT_W = 4;

    // Terminal settle count for a given hold time, truncated to the counter width.
    function automatic logic [CNT_W-1:0] settle_last(input int settle);
        return CNT_W'(settle - 1);
    endfunction

endpackage

// File: rtl/mux4to1.sv
// rtl/mux4to1.sv - combinational 4:1 bit selector driven by the scanner
module mux4to1 (
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic [1:0] S,
    output logic       Y
);

    always_comb begin
        Y = 1'b0;
        case (S)
            2'd0:    Y = I0;
            2'd1:    Y = I1;
            2'd2:    Y = I2;
            default: Y = I3;
        endcase
    end

endmodule

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// rtl/mux_scan_ctrl_settle_cnt.sv - loadable settle counter, tick on the last hold cycle of a channel
module settle_cnt
    import mux_scan_defs::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LAST_CNT = settle_last(SETTLE);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Combinational tick so the FSM samples on the same edge the count wraps.
    assign tick = en && (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST_CNT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE_CNT;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - sequences the mux select, samples Y per channel and hands off the word on valid/ready
module mux_scan_ctrl
    import mux_scan_defs::*;
#(
    parameter int SEL_W  = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [SEL_W-1:0]      S,
    input  logic                  Y,
    output logic                  busy,
    output logic [(2**SEL_W)-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready
);

    localparam int               N_CH     = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);
    localparam logic [SEL_W-1:0] ONE_SEL  = SEL_W'(1);

    scan_state_t      state;
    logic [N_CH-1:0]  shadow;
    logic             cnt_clr;
    logic             cnt_en;
    logic             tick;
    logic [CNT_W-1:0] cnt;

    // Every fresh scan starts the settle count at zero, whether from IDLE or a back-to-back restart.
    assign cnt_clr = start && ((state == IDLE) || ((state == DONE) && data_ready));
    assign cnt_en  = (state == SCAN);

    settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tick (tick),
        .cnt  (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            S          <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            shadow     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    S <= '0;
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end

                SCAN: begin
                    if (tick) begin
                        shadow[S] <= Y;
                        if (S == LAST_SEL) begin
                            // The last channel's bit bypasses the shadow so the word lands on this edge.
                            state      <= DONE;
                            busy       <= 1'b0;
                            data_valid <= 1'b1;
                            data_out   <= {Y, shadow[N_CH-2:0]};
                            S          <= '0;
                        end else begin
                            S <= S + ONE_SEL;
                        end
                    end
                end

                DONE: begin
                    S <= '0;
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        if (start) begin
                            state <= SCAN;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    S          <= '0;
                    busy       <= 1'b0;
                    data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed checks of mux_scan_ctrl closed-loop with mux4to1
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;

    logic       start_a, ready_a, y_a, busy_a, valid_a;
    logic [1:0] s_a;
    logic [3:0] data_a, in_a;

    logic       start_b, ready_b, y_b, busy_b, valid_b;
    logic [1:0] s_b;
    logic [3:0] data_b, in_b;

    int vectors;
    int miscompares;

    mux_scan_ctrl #(.SEL_W(2), .SETTLE(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .S          (s_a),
        .Y          (y_a),
        .busy       (busy_a),
        .data_out   (data_a),
        .data_valid (valid_a),
        .data_ready (ready_a)
    );

    mux4to1 mux_a (
        .I0 (in_a[0]), .I1 (in_a[1]), .I2 (in_a[2]), .I3 (in_a[3]),
        .S  (s_a),
        .Y  (y_a)
    );

    mux_scan_ctrl #(.SEL_W(2), .SETTLE(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .S          (s_b),
        .Y          (y_b),
        .busy       (busy_b),
        .data_out   (data_b),
        .data_valid (valid_b),
        .data_ready (ready_b)
    );

    mux4to1 mux_b (
        .I0 (in_b[0]), .I1 (in_b[1]), .I2 (in_b[2]), .I3 (in_b[3]),
        .S  (s_b),
        .Y  (y_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b0;
        start_a = 1'b0; ready_a = 1'b1; in_a = 4'b0000;
        start_b = 1'b0; ready_b = 1'b1; in_b = 4'b0000;

        #2 rst = 1'b1;
        #1;
        chk("reset_s",     32'(s_a),     32'd0);
        chk("reset_busy",  32'(busy_a),  32'd0);
        chk("reset_valid", 32'(valid_a), 32'd0);
        chk("reset_data",  32'(data_a),  32'd0);
        nxt();
        nxt();
        rst = 1'b0;
        nxt();

        // Basic scan: 0110, consumer always ready.
        in_a = 4'b0110;
        start_a = 1'b1;
        nxt();
        start_a = 1'b0;
        chk("t1_s0",    32'(s_a),     32'd0);
        chk("t1_busy0", 32'(busy_a),  32'd1);
        chk("t1_val0",  32'(valid_a), 32'd0);
        nxt(); chk("t1_s1", 32'(s_a), 32'd1); chk("t1_busy1", 32'(busy_a), 32'd1);
        nxt(); chk("t1_s2", 32'(s_a), 32'd2); chk("t1_busy2", 32'(busy_a), 32'd1);
        nxt(); chk("t1_s3", 32'(s_a), 32'd3); chk("t1_busy3", 32'(busy_a), 32'd1);
        nxt();
        chk("t1_valid", 32'(valid_a), 32'd1);
        chk("t1_data",  32'(data_a),  32'h6);
        chk("t1_busy4", 32'(busy_a),  32'd0);
        chk("t1_s_done", 32'(s_a),    32'd0);
        nxt();
        chk("t1_drop",  32'(valid_a), 32'd0);
        chk("t1_keep",  32'(data_a),  32'h6);

        // Backpressure: word 1001 held while inputs change under it.
        in_a = 4'b1001;
        ready_a = 1'b0;
        start_a = 1'b1;
        nxt();
        start_a = 1'b0;
        nxt(); nxt(); nxt(); nxt();
        chk("t2_valid", 32'(valid_a), 32'd1);
        chk("t2_data",  32'(data_a),  32'h9);
        in_a = 4'b0110;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) start_a = 1'b1;
            nxt();
            start_a = 1'b0;
            chk("t2_hold_valid", 32'(valid_a), 32'd1);
            chk("t2_hold_data",  32'(data_a),  32'h9);
            chk("t2_hold_busy",  32'(busy_a),  32'd0);
        end
        ready_a = 1'b1;
        nxt();
        chk("t2_drop_valid", 32'(valid_a), 32'd0);
        chk("t2_drop_busy",  32'(busy_a),  32'd0);

        // Mid-scan start pulse is ignored.
        start_a = 1'b1;
        nxt();
        start_a = 1'b0;
        nxt();
        chk("t3_s1", 32'(s_a), 32'd1);
        start_a = 1'b1;
        nxt();
        start_a = 1'b0;
        chk("t3_s2", 32'(s_a), 32'd2);
        nxt(); chk("t3_s3", 32'(s_a), 32'd3);
        nxt();
        chk("t3_valid", 32'(valid_a), 32'd1);
        chk("t3_data",  32'(data_a),  32'h6);
        nxt();
        chk("t3_drop", 32'(valid_a), 32'd0);
        nxt(); nxt(); nxt(); nxt();
        chk("t3_no_second_valid", 32'(valid_a), 32'd0);
        chk("t3_no_second_busy",  32'(busy_a),  32'd0);

        // Asynchronous reset mid-scan at S=2.
        in_a = 4'b1001;
        start_a = 1'b1;
        nxt();
        start_a = 1'b0;
        nxt(); nxt();
        chk("t4_s2_pre", 32'(s_a), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_s",     32'(s_a),     32'd0);
        chk("t4_rst_busy",  32'(busy_a),  32'd0);
        chk("t4_rst_valid", 32'(valid_a), 32'd0);
        chk("t4_rst_data",  32'(data_a),  32'd0);
        nxt();
        rst = 1'b0;
        nxt();
        start_a = 1'b1;
        nxt();
        start_a = 1'b0;
        nxt(); nxt(); nxt(); nxt();
        chk("t4_after_valid", 32'(valid_a), 32'd1);
        chk("t4_after_data",  32'(data_a),  32'h9);
        nxt();

        // SETTLE=3 instance: each select held three cycles.
        in_b = 4'b1001;
        start_b = 1'b1;
        nxt();
        start_b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("t5_s",     32'(s_b),     32'(k / 3));
            chk("t5_valid", 32'(valid_b), 32'd0);
            nxt();
        end
        chk("t5_done_valid", 32'(valid_b), 32'd1);
        chk("t5_done_data",  32'(data_b),  32'h9);
        nxt();
        chk("t5_drop", 32'(valid_b), 32'd0);

        // Back-to-back: ready and start on the same DONE edge.
        in_a = 4'b0110;
        ready_a = 1'b0;
        start_a = 1'b1;
        nxt();
        start_a = 1'b0;
        nxt(); nxt(); nxt(); nxt();
        chk("t6_first_valid", 32'(valid_a), 32'd1);
        chk("t6_first_data",  32'(data_a),  32'h6);
        ready_a = 1'b1;
        start_a = 1'b1;
        in_a    = 4'b1001;
        nxt();
        start_a = 1'b0;
        ready_a = 1'b0;
        chk("t6_restart_valid", 32'(valid_a), 32'd0);
        chk("t6_restart_busy",  32'(busy_a),  32'd1);
        chk("t6_restart_s",     32'(s_a),     32'd0);
        chk("t6_old_data",      32'(data_a),  32'h6);
        nxt(); nxt(); nxt();
        chk("t6_pre_valid", 32'(valid_a), 32'd0);
        nxt();
        chk("t6_second_valid", 32'(valid_a), 32'd1);
        chk("t6_second_data",  32'(data_a),  32'h9);
        ready_a = 1'b1;
        nxt();
        chk("t6_second_drop", 32'(valid_a), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
